// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end: opcode/bubble/reset defaults and the
// instruction-fetch FSM state type.
package cpu_pkg;

    localparam logic [15:0] RESET_PC_DEF  = 16'h0000;
    localparam logic [15:0] NOP_INSTR_DEF = 16'h0000;
    localparam logic [3:0]  OP_HLT_DEF    = 4'hF;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HALT  = 2'd2
    } if_state_t;

    function automatic logic has_opcode(input logic [15:0] word, input logic [3:0] op);
        return word[15:12] == op;
    endfunction

endpackage

// File: rtl/cpu_if_stage_if_id_pipe_reg.sv
// IF/ID pipeline register: flush inserts a bubble, load takes a fetched word,
// otherwise the contents hold. Flush wins over load.
module if_id_pipe_reg #(
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        flush,
    input  logic [15:0] next_instr,
    input  logic [15:0] next_pc,
    output logic [15:0] instr,
    output logic [15:0] pc,
    output logic        valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr <= NOP_INSTR;
            pc    <= 16'h0000;
            valid <= 1'b0;
        end else if (flush) begin
            instr <= NOP_INSTR;
            pc    <= 16'h0000;
            valid <= 1'b0;
        end else if (load) begin
            instr <= next_instr;
            pc    <= next_pc;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/cpu_if_stage.sv
// Instruction-fetch stage: PC, handshaked fetch FSM, stall skid buffer and redirect
// handling, feeding the IF/ID register. Optional counters under IF_PERF_CNT_EN.
module cpu_if_stage
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF,
    parameter logic [3:0]  OP_HLT    = OP_HLT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branchTake,
    input  logic [15:0] pcBranch,
    output logic        imemReq,
    output logic [15:0] imemAddr,
    input  logic        imemRdy,
    input  logic [15:0] imemData,
    output logic [15:0] instrD,
    output logic [15:0] pcD,
    output logic        validD,
    output logic        halted
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetchCnt,
    output logic [31:0] missCnt
`endif
);

    if_state_t   state, state_n;
    logic [15:0] pc, pc_n, pc_inc;
    logic        redir_pend, redir_pend_n;
    logic [15:0] redir_tgt, redir_tgt_n;
    logic        skid_vld, skid_vld_n;
    logic [15:0] skid_instr, skid_instr_n;
    logic [15:0] skid_pc, skid_pc_n;
    logic        halted_n;
    logic        pipe_load, pipe_flush;
    logic [15:0] pipe_instr, pipe_pc;
    logic        accept, take;

    assign pc_inc   = pc + 16'd2;
    assign imemAddr = pc;

    // A branch cycle never opens a new request: the old address is already dead.
    always_comb begin
        imemReq = 1'b0;
        case (state)
            FETCH:   imemReq = !stall && !skid_vld && !branchTake;
            WAIT:    imemReq = 1'b1;
            default: imemReq = 1'b0;
        endcase
        imemReq = imemReq && rst_n;
    end

    assign accept = imemReq && imemRdy;
    assign take   = accept && !branchTake && !redir_pend;

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        redir_pend_n = redir_pend;
        redir_tgt_n  = redir_tgt;
        skid_vld_n   = skid_vld;
        skid_instr_n = skid_instr;
        skid_pc_n    = skid_pc;
        halted_n     = halted;
        pipe_load    = 1'b0;
        pipe_flush   = 1'b0;
        pipe_instr   = imemData;
        pipe_pc      = pc_inc;

        if (branchTake) begin
            pipe_flush = 1'b1;
            skid_vld_n = 1'b0;
            halted_n   = 1'b0;
            if (state == WAIT && !imemRdy) begin
                // Memory still owes us a word at the old address; retire it first.
                redir_pend_n = 1'b1;
                redir_tgt_n  = pcBranch;
            end else begin
                pc_n         = pcBranch;
                state_n      = FETCH;
                redir_pend_n = 1'b0;
            end
        end else begin
            if (state == WAIT && imemRdy && redir_pend) begin
                pc_n         = redir_tgt;
                state_n      = FETCH;
                redir_pend_n = 1'b0;
            end else if (take) begin
                if (stall) begin
                    skid_vld_n   = 1'b1;
                    skid_instr_n = imemData;
                    skid_pc_n    = pc_inc;
                end else begin
                    pipe_load = 1'b1;
                end
                if (has_opcode(imemData, OP_HLT)) begin
                    state_n  = HALT;
                    halted_n = 1'b1;
                end else begin
                    pc_n    = pc_inc;
                    state_n = FETCH;
                end
            end else if (state == FETCH && imemReq) begin
                state_n = WAIT;
            end

            // Decode consumes IF/ID every unstalled cycle; refill from skid or bubble.
            if (!pipe_load && !stall) begin
                if (skid_vld) begin
                    pipe_load  = 1'b1;
                    pipe_instr = skid_instr;
                    pipe_pc    = skid_pc;
                    skid_vld_n = 1'b0;
                end else begin
                    pipe_flush = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            redir_pend <= 1'b0;
            skid_vld   <= 1'b0;
            halted     <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            redir_pend <= redir_pend_n;
            skid_vld   <= skid_vld_n;
            halted     <= halted_n;
        end
    end

    // Payload registers are qualified by redir_pend / skid_vld and need no reset.
    always_ff @(posedge clk) begin
        redir_tgt  <= redir_tgt_n;
        skid_instr <= skid_instr_n;
        skid_pc    <= skid_pc_n;
    end

    if_id_pipe_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (pipe_load),
        .flush      (pipe_flush),
        .next_instr (pipe_instr),
        .next_pc    (pipe_pc),
        .instr      (instrD),
        .pc         (pcD),
        .valid      (validD)
    );

`ifdef IF_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetchCnt <= 32'd0;
            missCnt  <= 32'd0;
        end else begin
            if (pipe_load && !pipe_flush)
                fetchCnt <= sat_inc(fetchCnt);
            if (state == WAIT)
                missCnt <= sat_inc(missCnt);
        end
    end
`endif

endmodule

// File: tb/tb_cpu_if_stage.sv
// Bench for cpu_if_stage: directed scenarios then randomized traffic, all checked
// against a cycle-level behavioural model of the fetch stage.
module tb_cpu_if_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, branchTake, imemRdy;
    logic [15:0] pcBranch, imemData;
    logic        imemReq, validD, halted;
    logic [15:0] imemAddr, instrD, pcD;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetchCnt, missCnt;
`endif

    int errors = 0;
    int checks = 0;

    cpu_if_stage dut (
`ifdef IF_PERF_CNT_EN
        .fetchCnt   (fetchCnt),
        .missCnt    (missCnt),
`endif
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .branchTake (branchTake),
        .pcBranch   (pcBranch),
        .imemReq    (imemReq),
        .imemAddr   (imemAddr),
        .imemRdy    (imemRdy),
        .imemData   (imemData),
        .instrD     (instrD),
        .pcD        (pcD),
        .validD     (validD),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
        logic        valid;
    } ent_t;

    logic [15:0] mem [256];

    // Behavioural model: abstract fetch status plus a FIFO for the skid slot.
    logic [15:0] m_pc, m_tgt;
    bit          m_wait, m_halt, m_pend;
    ent_t        m_ifid;
    ent_t        m_skid[$];
    int unsigned m_fetch, m_miss;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_pc = 16'h0000; m_tgt = 16'h0000;
        m_wait = 0; m_halt = 0; m_pend = 0;
        m_skid.delete();
        m_ifid = '{instr: 16'h0000, pc: 16'h0000, valid: 1'b0};
        m_fetch = 0; m_miss = 0;
    endfunction

    task automatic cycle(input bit s, input bit b, input logic [15:0] tgt, input bit r);
        bit          req, got, loaded;
        logic [15:0] word;
        ent_t        w;
        stall = s; branchTake = b; pcBranch = tgt; imemRdy = r;
        word = mem[imemAddr[8:1]];
        imemData = word;
        #1;
        req = m_halt ? 1'b0 : (m_wait ? 1'b1 : (!s && m_skid.size() == 0 && !b));
        chk("imemReq", imemReq, req);
        chk("imemAddr", imemAddr, m_pc);
        chk("instrD", instrD, m_ifid.instr);
        chk("pcD", pcD, m_ifid.pc);
        chk("validD", validD, m_ifid.valid);
        chk("halted", halted, m_halt);
`ifdef IF_PERF_CNT_EN
        chk("fetchCnt", fetchCnt, m_fetch);
        chk("missCnt", missCnt, m_miss);
`endif
        if (m_wait) m_miss++;
        got = req && r;
        loaded = 0;
        if (b) begin
            m_ifid = '{instr: 16'h0000, pc: 16'h0000, valid: 1'b0};
            m_skid.delete();
            m_halt = 0;
            if (m_wait && !r) begin
                m_pend = 1; m_tgt = tgt;
            end else begin
                m_pc = tgt; m_wait = 0; m_pend = 0;
            end
        end else begin
            if (got && m_pend) begin
                m_pc = m_tgt; m_pend = 0; m_wait = 0;
            end else if (got) begin
                w = '{instr: word, pc: m_pc + 16'd2, valid: 1'b1};
                if (s) m_skid.push_back(w);
                else begin m_ifid = w; loaded = 1; m_fetch++; end
                m_wait = 0;
                if (word[15:12] == 4'hF) m_halt = 1;
                else m_pc = m_pc + 16'd2;
            end else if (req) begin
                m_wait = 1;
            end
            if (!loaded && !s) begin
                if (m_skid.size() != 0) begin
                    m_ifid = m_skid.pop_front();
                    m_fetch++;
                end else begin
                    m_ifid = '{instr: 16'h0000, pc: 16'h0000, valid: 1'b0};
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        stall = 0; branchTake = 0; imemRdy = 0;
        #1;
    endtask

    logic [15:0] hold_instr, hold_pc;

    initial begin
        rst_n = 0; stall = 0; branchTake = 0; pcBranch = 0; imemRdy = 0; imemData = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h1123; mem[1] = 16'h2234; mem[2] = 16'h3345;
        mem[3] = 16'h4456; mem[4] = 16'h3000; mem[8] = 16'h5566;
        mem[16'h20] = 16'hF000;
        model_reset();
        #1;
        chk("rst_validD", validD, 1'b0);
        chk("rst_imemReq", imemReq, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1; #1;

        // Zero-wait streaming.
        chk("t1_addr0", imemAddr, 16'h0000);
        cycle(0, 0, 16'h0, 1);
        chk("t1_instr0", instrD, 16'h1123); chk("t1_pc0", pcD, 16'h0002);
        cycle(0, 0, 16'h0, 1);
        chk("t1_instr1", instrD, 16'h2234); chk("t1_pc1", pcD, 16'h0004);
        chk("t1_addr2", imemAddr, 16'h0004);

        // Three-cycle miss at address 4.
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 16'h0, 0);
            chk("t2_addr_hold", imemAddr, 16'h0004);
            chk("t2_req_hold", imemReq, 1'b1);
        end
        cycle(0, 0, 16'h0, 1);
        chk("t2_instr", instrD, 16'h3345);
`ifdef IF_PERF_CNT_EN
        chk("t2_missCnt", missCnt, 32'd3);
`endif

        // Word at 6 returns during a stall and lands one cycle after release.
        cycle(0, 0, 16'h0, 0);
        hold_instr = instrD; hold_pc = pcD;
        cycle(1, 0, 16'h0, 1);
        chk("t3_instr_hold", instrD, hold_instr); chk("t3_pc_hold", pcD, hold_pc);
        cycle(1, 0, 16'h0, 0);
        chk("t3_instr_hold2", instrD, hold_instr);
        cycle(0, 0, 16'h0, 0);
        chk("t3_instr", instrD, 16'h4456); chk("t3_pc", pcD, 16'h0008);

        // Redirect during a miss drops the late word.
        cycle(0, 0, 16'h0, 0);
        cycle(0, 1, 16'h0040, 0);
        chk("t4_valid_br", validD, 1'b0);
        cycle(0, 0, 16'h0, 1);
        chk("t4_valid_drop", validD, 1'b0);
        chk("t4_addr", imemAddr, 16'h0040);

        // HLT then resume.
        cycle(0, 0, 16'h0, 1);
        chk("t5_instr", instrD, 16'hF000); chk("t5_valid", validD, 1'b1);
        chk("t5_halted", halted, 1'b1);
        cycle(0, 0, 16'h0, 1);
        chk("t5_req_off", imemReq, 1'b0); chk("t5_bubble", validD, 1'b0);
        cycle(0, 1, 16'h0010, 0);
        chk("t5_resume_halted", halted, 1'b0);
        chk("t5_resume_addr", imemAddr, 16'h0010);
        chk("t5_resume_req", imemReq, 1'b1);

        // Asynchronous reset in the middle of a miss.
        cycle(0, 0, 16'h0, 1);
        cycle(0, 0, 16'h0, 0);
        rst_n = 0; #1;
        chk("t6_req", imemReq, 1'b0); chk("t6_valid", validD, 1'b0);
        chk("t6_instr", instrD, 16'h0000); chk("t6_halted", halted, 1'b0);
        chk("t6_addr", imemAddr, 16'h0000);
        model_reset();
        @(posedge clk); @(negedge clk); rst_n = 1; #1;
        chk("t6_post_addr", imemAddr, 16'h0000);
        chk("t6_post_req", imemReq, 1'b1);

        // Randomized traffic including address wrap.
        for (int n = 0; n < 3000; n++) begin
            bit          s, b, r;
            logic [15:0] tgt;
            s = ($urandom_range(0, 99) < 20);
            b = ($urandom_range(0, 99) < 8);
            r = ($urandom_range(0, 99) < 60);
            tgt = ($urandom_range(0, 9) == 0) ? 16'hFFFC : 16'($urandom_range(0, 255) * 2);
            cycle(s, b, tgt, r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
